// File: rtl/id_ex_if.sv
// ID/EX pipeline bundle: decode-stage fields flowing in, execute-stage
// copies (plus slot status and bubble counter) flowing out.
// master = decode side / driver, slave = the id_ex_reg pipeline register.
interface id_ex_if #(
  parameter int REG_ADDR_W = 4
);
  // decode-stage fields
  logic [31:0]           pc;
  logic                  wb_en;
  logic                  mem_r_en;
  logic                  mem_w_en;
  logic [3:0]            exe_cmd;
  logic                  b;
  logic                  s;
  logic [3:0]            sr;
  logic [31:0]           val_rn;
  logic [31:0]           val_rm;
  logic                  imm;
  logic [11:0]           shift_operand;
  logic [23:0]           signed_imm_24;
  logic [REG_ADDR_W-1:0] dest;
  logic [REG_ADDR_W-1:0] src1;
  logic [REG_ADDR_W-1:0] src2;

  // execute-stage copies
  logic [31:0]           pc_out;
  logic                  wb_en_out;
  logic                  mem_r_en_out;
  logic                  mem_w_en_out;
  logic [3:0]            exe_cmd_out;
  logic                  b_out;
  logic                  s_out;
  logic [3:0]            sr_out;
  logic [31:0]           val_rn_out;
  logic [31:0]           val_rm_out;
  logic                  imm_out;
  logic [11:0]           shift_operand_out;
  logic [23:0]           signed_imm_24_out;
  logic [REG_ADDR_W-1:0] dest_out;
  logic [REG_ADDR_W-1:0] src1_out;
  logic [REG_ADDR_W-1:0] src2_out;
  logic                  ld_str_out;
  logic                  valid_out;
  logic [15:0]           bubble_cnt;

  modport master (
    output pc, wb_en, mem_r_en, mem_w_en, exe_cmd, b, s, sr, val_rn, val_rm,
           imm, shift_operand, signed_imm_24, dest, src1, src2,
    input  pc_out, wb_en_out, mem_r_en_out, mem_w_en_out, exe_cmd_out, b_out,
           s_out, sr_out, val_rn_out, val_rm_out, imm_out, shift_operand_out,
           signed_imm_24_out, dest_out, src1_out, src2_out, ld_str_out,
           valid_out, bubble_cnt
  );

  modport slave (
    input  pc, wb_en, mem_r_en, mem_w_en, exe_cmd, b, s, sr, val_rn, val_rm,
           imm, shift_operand, signed_imm_24, dest, src1, src2,
    output pc_out, wb_en_out, mem_r_en_out, mem_w_en_out, exe_cmd_out, b_out,
           s_out, sr_out, val_rn_out, val_rm_out, imm_out, shift_operand_out,
           signed_imm_24_out, dest_out, src1_out, src2_out, ld_str_out,
           valid_out, bubble_cnt
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register.
// Captures the decoded instruction each cycle; freeze holds the slot, flush
// replaces it with an all-zero NOP bubble and counts it (saturating at FFFF).
// Reset is synchronous, active-low, and dominates flush/freeze.
// Optional macro FORWARDING_EN: registers src1/src2 for the forwarding unit;
// when undefined, src1_out/src2_out are tied to zero with no storage.
module id_ex_reg #(
  parameter int REG_ADDR_W = 4
) (
  input logic    clk,
  input logic    rst_n,
  input logic    freeze,
  input logic    flush,
  id_ex_if.slave bus
);

  typedef struct packed {
    logic [31:0]           pc;
    logic                  wb_en;
    logic                  mem_r_en;
    logic                  mem_w_en;
    logic [3:0]            exe_cmd;
    logic                  b;
    logic                  s;
    logic [3:0]            sr;
    logic [31:0]           val_rn;
    logic [31:0]           val_rm;
    logic                  imm;
    logic [11:0]           shift_operand;
    logic [23:0]           signed_imm_24;
    logic [REG_ADDR_W-1:0] dest;
    logic                  ld_str;
    logic                  valid;
  } stage_t;

  stage_t      stage_r;
  stage_t      load_s;
  logic [15:0] bubble_cnt_r;

  // Assemble the word captured on a normal load; ld_str is derived here so
  // the execute stage sees it straight from a flop.
  always_comb begin
    load_s               = '0;
    load_s.pc            = bus.pc;
    load_s.wb_en         = bus.wb_en;
    load_s.mem_r_en      = bus.mem_r_en;
    load_s.mem_w_en      = bus.mem_w_en;
    load_s.exe_cmd       = bus.exe_cmd;
    load_s.b             = bus.b;
    load_s.s             = bus.s;
    load_s.sr            = bus.sr;
    load_s.val_rn        = bus.val_rn;
    load_s.val_rm        = bus.val_rm;
    load_s.imm           = bus.imm;
    load_s.shift_operand = bus.shift_operand;
    load_s.signed_imm_24 = bus.signed_imm_24;
    load_s.dest          = bus.dest;
    load_s.ld_str        = bus.mem_r_en | bus.mem_w_en;
    load_s.valid         = 1'b1;
  end

  // Pipeline slot: reset, then flush (bubble), then freeze (hold), else load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_r <= '0;
    end else if (flush) begin
      stage_r <= '0;
    end else if (!freeze) begin
      stage_r <= load_s;
    end else begin
      stage_r <= stage_r;
    end
  end

  // Bubble counter: one per flush cycle, sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_cnt_r <= 16'h0000;
    end else if (flush && (bubble_cnt_r != 16'hFFFF)) begin
      bubble_cnt_r <= bubble_cnt_r + 16'h0001;
    end else begin
      bubble_cnt_r <= bubble_cnt_r;
    end
  end

`ifdef FORWARDING_EN
  logic [REG_ADDR_W-1:0] src1_r;
  logic [REG_ADDR_W-1:0] src2_r;

  // Source register numbers for the forwarding unit, same priority as the slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src1_r <= {REG_ADDR_W{1'b0}};
      src2_r <= {REG_ADDR_W{1'b0}};
    end else if (flush) begin
      src1_r <= {REG_ADDR_W{1'b0}};
      src2_r <= {REG_ADDR_W{1'b0}};
    end else if (!freeze) begin
      src1_r <= bus.src1;
      src2_r <= bus.src2;
    end else begin
      src1_r <= src1_r;
      src2_r <= src2_r;
    end
  end

  assign bus.src1_out = src1_r;
  assign bus.src2_out = src2_r;
`else
  // No forwarding unit downstream: source numbers are not stored.
  logic unused_src_s;
  assign unused_src_s = ^{bus.src1, bus.src2};
  assign bus.src1_out = {REG_ADDR_W{1'b0}};
  assign bus.src2_out = {REG_ADDR_W{1'b0}};
`endif

  assign bus.pc_out            = stage_r.pc;
  assign bus.wb_en_out         = stage_r.wb_en;
  assign bus.mem_r_en_out      = stage_r.mem_r_en;
  assign bus.mem_w_en_out      = stage_r.mem_w_en;
  assign bus.exe_cmd_out       = stage_r.exe_cmd;
  assign bus.b_out             = stage_r.b;
  assign bus.s_out             = stage_r.s;
  assign bus.sr_out            = stage_r.sr;
  assign bus.val_rn_out        = stage_r.val_rn;
  assign bus.val_rm_out        = stage_r.val_rm;
  assign bus.imm_out           = stage_r.imm;
  assign bus.shift_operand_out = stage_r.shift_operand;
  assign bus.signed_imm_24_out = stage_r.signed_imm_24;
  assign bus.dest_out          = stage_r.dest;
  assign bus.ld_str_out        = stage_r.ld_str;
  assign bus.valid_out         = stage_r.valid;
  assign bus.bubble_cnt        = bubble_cnt_r;

endmodule
